qpu_exu_oitf: RTL and testbench

QPU_EXU_OITF -- requirements
Module: qpu_exu_oitf

---
 rtl/qpu_exu_oitf.sv | 184 ++++++++++++++++++
 tb/tb_qpu_exu_oitf.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/qpu_exu_oitf.sv
// Outstanding-instruction tracking FIFO for the QPU execute unit.
// Records destination registers and qubit lists of long-pipe instructions
// in flight, and flags register (RAW/WAW) and qubit-list overlaps against
// the instruction currently being dispatched. Stalling on these flags is
// left to the dispatch unit.
module qpu_exu_oitf #(
  parameter  int OITF_DEPTH = 4,
  parameter  int RFIDX_W    = 5,
  parameter  int QUBIT_NUM  = 8,
  localparam int PTR_W      = (OITF_DEPTH > 1) ? $clog2(OITF_DEPTH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  // dispatch side
  input  logic                 disp_oitf_ena,
  output logic                 disp_oitf_ready,
  input  logic                 disp_oitf_rs1en,
  input  logic                 disp_oitf_rs2en,
  input  logic                 disp_oitf_rdwen,
  input  logic [RFIDX_W-1:0]   disp_oitf_rs1idx,
  input  logic [RFIDX_W-1:0]   disp_oitf_rs2idx,
  input  logic [RFIDX_W-1:0]   disp_oitf_rdidx,
  input  logic                 disp_oitf_qfren,
  input  logic [QUBIT_NUM-1:0] disp_oitf_qubitlist,
  // hazard flags
  output logic                 oitfrd_match_disprs1,
  output logic                 oitfrd_match_disprs2,
  output logic                 oitfrd_match_disprd,
  output logic                 oitfqf_match_dispql,
  // retire side
  input  logic                 ret_ena,
  output logic                 ret_rdwen,
  output logic [RFIDX_W-1:0]   ret_rdidx,
  output logic [QUBIT_NUM-1:0] ret_qubitlist,
  // status
  output logic                 oitf_empty,
  output logic [PTR_W-1:0]     dis_ptr,
  output logic [PTR_W-1:0]     ret_ptr
);

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(OITF_DEPTH - 1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  // Entry storage
  logic [OITF_DEPTH-1:0] valid_q, valid_d;
  logic [OITF_DEPTH-1:0] rdwen_q, rdwen_d;
  logic [OITF_DEPTH-1:0] qfren_q, qfren_d;
  logic [RFIDX_W-1:0]    rdidx_q [OITF_DEPTH];
  logic [RFIDX_W-1:0]    rdidx_d [OITF_DEPTH];
  logic [QUBIT_NUM-1:0]  qlist_q [OITF_DEPTH];
  logic [QUBIT_NUM-1:0]  qlist_d [OITF_DEPTH];

  // Pointers; the wrap bits tell full from empty when the pointers coincide
  logic [PTR_W-1:0] dis_ptr_q, dis_ptr_d;
  logic [PTR_W-1:0] ret_ptr_q, ret_ptr_d;
  logic             dis_wrap_q, dis_wrap_d;
  logic             ret_wrap_q, ret_wrap_d;

  logic full_s;
  logic empty_s;
  logic alloc_s;
  logic retire_s;

  assign empty_s  = (dis_ptr_q == ret_ptr_q) && (dis_wrap_q == ret_wrap_q);
  assign full_s   = (dis_ptr_q == ret_ptr_q) && (dis_wrap_q != ret_wrap_q);
  // Ready looks at registered occupancy only, so a retire in the same
  // cycle cannot let an allocate slip into a full FIFO.
  assign alloc_s  = disp_oitf_ena & ~full_s;
  assign retire_s = ret_ena & ~empty_s;

  assign disp_oitf_ready = ~full_s;
  assign oitf_empty      = empty_s;
  assign dis_ptr         = dis_ptr_q;
  assign ret_ptr         = ret_ptr_q;

  // Oldest-entry fields, forced to zero while nothing is outstanding
  assign ret_rdwen     = empty_s ? 1'b0 : rdwen_q[ret_ptr_q];
  assign ret_rdidx     = empty_s ? {RFIDX_W{1'b0}} : rdidx_q[ret_ptr_q];
  assign ret_qubitlist = empty_s ? {QUBIT_NUM{1'b0}} : qlist_q[ret_ptr_q];

  // Hazard match against registered entries only (new entries visible next cycle)
  always_comb begin
    logic hit_rs1;
    logic hit_rs2;
    logic hit_rd;
    logic hit_ql;
    hit_rs1 = 1'b0;
    hit_rs2 = 1'b0;
    hit_rd  = 1'b0;
    hit_ql  = 1'b0;
    for (int i = 0; i < OITF_DEPTH; i++) begin
      if (valid_q[i] && rdwen_q[i]) begin
        hit_rs1 = hit_rs1 | (rdidx_q[i] == disp_oitf_rs1idx);
        hit_rs2 = hit_rs2 | (rdidx_q[i] == disp_oitf_rs2idx);
        hit_rd  = hit_rd  | (rdidx_q[i] == disp_oitf_rdidx);
      end else begin
        hit_rs1 = hit_rs1;
        hit_rs2 = hit_rs2;
        hit_rd  = hit_rd;
      end
      if (valid_q[i] && qfren_q[i]) begin
        hit_ql = hit_ql | ((qlist_q[i] & disp_oitf_qubitlist) != {QUBIT_NUM{1'b0}});
      end else begin
        hit_ql = hit_ql;
      end
    end
    // x0 is hardwired, so reading it never creates a hazard
    oitfrd_match_disprs1 = disp_oitf_rs1en & (disp_oitf_rs1idx != {RFIDX_W{1'b0}}) & hit_rs1;
    oitfrd_match_disprs2 = disp_oitf_rs2en & (disp_oitf_rs2idx != {RFIDX_W{1'b0}}) & hit_rs2;
    oitfrd_match_disprd  = disp_oitf_rdwen & (disp_oitf_rdidx  != {RFIDX_W{1'b0}}) & hit_rd;
    oitfqf_match_dispql  = disp_oitf_qfren & hit_ql;
  end

  // Next-state: retire frees the oldest slot, allocate fills the newest
  always_comb begin
    valid_d    = valid_q;
    rdwen_d    = rdwen_q;
    qfren_d    = qfren_q;
    rdidx_d    = rdidx_q;
    qlist_d    = qlist_q;
    dis_ptr_d  = dis_ptr_q;
    ret_ptr_d  = ret_ptr_q;
    dis_wrap_d = dis_wrap_q;
    ret_wrap_d = ret_wrap_q;

    if (retire_s) begin
      valid_d[ret_ptr_q] = 1'b0;
      ret_ptr_d          = ret_ptr_q + PTR_ONE;
      if (ret_ptr_q == PTR_LAST) begin
        ret_wrap_d = ~ret_wrap_q;
      end else begin
        ret_wrap_d = ret_wrap_q;
      end
    end else begin
      ret_ptr_d = ret_ptr_q;
    end

    if (alloc_s) begin
      valid_d[dis_ptr_q] = 1'b1;
      rdwen_d[dis_ptr_q] = disp_oitf_rdwen;
      qfren_d[dis_ptr_q] = disp_oitf_qfren;
      rdidx_d[dis_ptr_q] = disp_oitf_rdidx;
      qlist_d[dis_ptr_q] = disp_oitf_qubitlist;
      dis_ptr_d          = dis_ptr_q + PTR_ONE;
      if (dis_ptr_q == PTR_LAST) begin
        dis_wrap_d = ~dis_wrap_q;
      end else begin
        dis_wrap_d = dis_wrap_q;
      end
    end else begin
      dis_ptr_d = dis_ptr_q;
    end
  end

  // State registers; reset clears everything and overrides allocate/retire
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= {OITF_DEPTH{1'b0}};
      rdwen_q    <= {OITF_DEPTH{1'b0}};
      qfren_q    <= {OITF_DEPTH{1'b0}};
      dis_ptr_q  <= {PTR_W{1'b0}};
      ret_ptr_q  <= {PTR_W{1'b0}};
      dis_wrap_q <= 1'b0;
      ret_wrap_q <= 1'b0;
      for (int i = 0; i < OITF_DEPTH; i++) begin
        rdidx_q[i] <= {RFIDX_W{1'b0}};
        qlist_q[i] <= {QUBIT_NUM{1'b0}};
      end
    end else begin
      valid_q    <= valid_d;
      rdwen_q    <= rdwen_d;
      qfren_q    <= qfren_d;
      dis_ptr_q  <= dis_ptr_d;
      ret_ptr_q  <= ret_ptr_d;
      dis_wrap_q <= dis_wrap_d;
      ret_wrap_q <= ret_wrap_d;
      for (int i = 0; i < OITF_DEPTH; i++) begin
        rdidx_q[i] <= rdidx_d[i];
        qlist_q[i] <= qlist_d[i];
      end
    end
  end

endmodule

// File: tb/tb_qpu_exu_oitf.sv
// Directed self-checking bench for qpu_exu_oitf (default parameters).
module tb_qpu_exu_oitf;

  logic       clk;
  logic       rst;
  logic       disp_oitf_ena;
  logic       disp_oitf_ready;
  logic       disp_oitf_rs1en;
  logic       disp_oitf_rs2en;
  logic       disp_oitf_rdwen;
  logic [4:0] disp_oitf_rs1idx;
  logic [4:0] disp_oitf_rs2idx;
  logic [4:0] disp_oitf_rdidx;
  logic       disp_oitf_qfren;
  logic [7:0] disp_oitf_qubitlist;
  logic       oitfrd_match_disprs1;
  logic       oitfrd_match_disprs2;
  logic       oitfrd_match_disprd;
  logic       oitfqf_match_dispql;
  logic       ret_ena;
  logic       ret_rdwen;
  logic [4:0] ret_rdidx;
  logic [7:0] ret_qubitlist;
  logic       oitf_empty;
  logic [1:0] dis_ptr;
  logic [1:0] ret_ptr;

  int err_cnt;
  int chk_cnt;

  qpu_exu_oitf dut (
    .clk                  (clk),
    .rst                  (rst),
    .disp_oitf_ena        (disp_oitf_ena),
    .disp_oitf_ready      (disp_oitf_ready),
    .disp_oitf_rs1en      (disp_oitf_rs1en),
    .disp_oitf_rs2en      (disp_oitf_rs2en),
    .disp_oitf_rdwen      (disp_oitf_rdwen),
    .disp_oitf_rs1idx     (disp_oitf_rs1idx),
    .disp_oitf_rs2idx     (disp_oitf_rs2idx),
    .disp_oitf_rdidx      (disp_oitf_rdidx),
    .disp_oitf_qfren      (disp_oitf_qfren),
    .disp_oitf_qubitlist  (disp_oitf_qubitlist),
    .oitfrd_match_disprs1 (oitfrd_match_disprs1),
    .oitfrd_match_disprs2 (oitfrd_match_disprs2),
    .oitfrd_match_disprd  (oitfrd_match_disprd),
    .oitfqf_match_dispql  (oitfqf_match_dispql),
    .ret_ena              (ret_ena),
    .ret_rdwen            (ret_rdwen),
    .ret_rdidx            (ret_rdidx),
    .ret_qubitlist        (ret_qubitlist),
    .oitf_empty           (oitf_empty),
    .dis_ptr              (dis_ptr),
    .ret_ptr              (ret_ptr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // advance one rising edge, land 1 ns after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic alloc(input logic [4:0] idx);
    disp_oitf_ena   = 1'b1;
    disp_oitf_rdwen = 1'b1;
    disp_oitf_rdidx = idx;
    tick();
    disp_oitf_ena   = 1'b0;
    disp_oitf_rdwen = 1'b0;
  endtask

  logic [4:0] exp_q[$];
  logic [1:0] exp_rp;

  initial begin
    err_cnt = 0;
    chk_cnt = 0;
    rst = 1'b1;
    disp_oitf_ena = 1'b0; disp_oitf_rs1en = 1'b0; disp_oitf_rs2en = 1'b0;
    disp_oitf_rdwen = 1'b0; disp_oitf_rs1idx = 5'd0; disp_oitf_rs2idx = 5'd0;
    disp_oitf_rdidx = 5'd0; disp_oitf_qfren = 1'b0; disp_oitf_qubitlist = 8'd0;
    ret_ena = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // reset state, with a lookup already presented
    disp_oitf_rs1en = 1'b1; disp_oitf_rs1idx = 5'd3;
    #1;
    chk("rst_ready", disp_oitf_ready, 1'b1);
    chk("rst_empty", oitf_empty, 1'b1);
    chk("rst_dis_ptr", dis_ptr, 2'd0);
    chk("rst_ret_ptr", ret_ptr, 2'd0);
    chk("rst_ret_rdidx", ret_rdidx, 5'd0);
    chk("rst_ret_rdwen", ret_rdwen, 1'b0);
    chk("rst_ret_ql", ret_qubitlist, 8'd0);
    chk("rst_match_rs1", oitfrd_match_disprs1, 1'b0);

    // RAW on rd=3; not visible in the allocating cycle
    disp_oitf_ena = 1'b1; disp_oitf_rdwen = 1'b1; disp_oitf_rdidx = 5'd3;
    #1;
    chk("same_cycle_rs1", oitfrd_match_disprs1, 1'b0);
    tick();
    disp_oitf_ena = 1'b0;
    chk("a1_dis_ptr", dis_ptr, 2'd1);
    chk("a1_empty", oitf_empty, 1'b0);
    chk("a1_ret_rdidx", ret_rdidx, 5'd3);
    chk("a1_ret_rdwen", ret_rdwen, 1'b1);
    chk("raw_rs1_hit", oitfrd_match_disprs1, 1'b1);
    chk("waw_rd_hit", oitfrd_match_disprd, 1'b1);
    disp_oitf_rs2en = 1'b1; disp_oitf_rs2idx = 5'd3; disp_oitf_rdidx = 5'd4;
    #1;
    chk("raw_rs2_hit", oitfrd_match_disprs2, 1'b1);
    chk("waw_rd_miss", oitfrd_match_disprd, 1'b0);
    disp_oitf_rs1idx = 5'd0;
    #1;
    chk("raw_rs1_x0", oitfrd_match_disprs1, 1'b0);
    disp_oitf_rs1idx = 5'd3; disp_oitf_rs1en = 1'b0;
    #1;
    chk("raw_rs1_en0", oitfrd_match_disprs1, 1'b0);
    disp_oitf_rs1en = 1'b1; disp_oitf_rs2en = 1'b0; disp_oitf_rdwen = 1'b0;
    ret_ena = 1'b1;
    tick();
    ret_ena = 1'b0;
    chk("r1_empty", oitf_empty, 1'b1);
    chk("r1_ret_ptr", ret_ptr, 2'd1);
    chk("r1_match_gone", oitfrd_match_disprs1, 1'b0);
    chk("r1_ret_rdidx", ret_rdidx, 5'd0);
    ret_ena = 1'b1;
    tick();
    ret_ena = 1'b0;
    chk("ret_empty_ign", ret_ptr, 2'd1);

    // fill to full, ignored fifth allocate, retire reopens
    do_reset();
    chk("re_rst_ptr", ret_ptr, 2'd0);
    alloc(5'd4); alloc(5'd5); alloc(5'd6); alloc(5'd7);
    chk("full_ready", disp_oitf_ready, 1'b0);
    chk("full_dis_ptr", dis_ptr, 2'd0);
    chk("full_empty", oitf_empty, 1'b0);
    alloc(5'd9);
    disp_oitf_rs1idx = 5'd9;
    #1;
    chk("ovf_dis_ptr", dis_ptr, 2'd0);
    chk("ovf_ret_rdidx", ret_rdidx, 5'd4);
    chk("ovf_not_stored", oitfrd_match_disprs1, 1'b0);
    ret_ena = 1'b1;
    #1;
    chk("ready_no_bypass", disp_oitf_ready, 1'b0);
    tick();
    ret_ena = 1'b0;
    chk("post_ret_ready", disp_oitf_ready, 1'b1);
    chk("post_ret_rdidx", ret_rdidx, 5'd5);

    // full plus simultaneous ena and ret_ena: only the retire happens
    alloc(5'd10);
    chk("refull_ready", disp_oitf_ready, 1'b0);
    disp_oitf_ena = 1'b1; disp_oitf_rdwen = 1'b1; disp_oitf_rdidx = 5'd11; ret_ena = 1'b1;
    tick();
    chk("both_full_dis", dis_ptr, 2'd1);
    chk("both_full_ret", ret_ptr, 2'd2);
    chk("both_full_ready", disp_oitf_ready, 1'b1);
    chk("both_full_rdidx", ret_rdidx, 5'd6);
    disp_oitf_rdidx = 5'd12;
    tick();
    disp_oitf_ena = 1'b0; disp_oitf_rdwen = 1'b0; ret_ena = 1'b0;
    chk("both_dis", dis_ptr, 2'd2);
    chk("both_ret", ret_ptr, 2'd3);
    chk("both_ready", disp_oitf_ready, 1'b1);
    chk("both_rdidx", ret_rdidx, 5'd7);
    disp_oitf_rs1idx = 5'd12;
    #1;
    chk("both_new_hit", oitfrd_match_disprs1, 1'b1);
    disp_oitf_rs1idx = 5'd6;
    #1;
    chk("both_old_miss", oitfrd_match_disprs1, 1'b0);

    // qubit-list overlap
    do_reset();
    disp_oitf_ena = 1'b1; disp_oitf_qfren = 1'b1; disp_oitf_qubitlist = 8'b0000_0101;
    disp_oitf_rdwen = 1'b0; disp_oitf_rdidx = 5'd3;
    tick();
    disp_oitf_ena = 1'b0;
    disp_oitf_rs1idx = 5'd3;
    disp_oitf_qubitlist = 8'b0000_0100;
    #1;
    chk("ql_stored", ret_qubitlist, 8'b0000_0101);
    chk("ql_hit", oitfqf_match_dispql, 1'b1);
    chk("rdwen0_no_raw", oitfrd_match_disprs1, 1'b0);
    disp_oitf_qubitlist = 8'b0000_1000;
    #1;
    chk("ql_miss", oitfqf_match_dispql, 1'b0);
    disp_oitf_qubitlist = 8'b0000_0100; disp_oitf_qfren = 1'b0;
    #1;
    chk("ql_qfren0", oitfqf_match_dispql, 1'b0);
    disp_oitf_qfren = 1'b1;
    ret_ena = 1'b1;
    tick();
    ret_ena = 1'b0;
    chk("ql_retired", oitfqf_match_dispql, 1'b0);
    disp_oitf_qfren = 1'b0; disp_oitf_qubitlist = 8'd0;

    // reset overrides a concurrent allocate
    do_reset();
    alloc(5'd1); alloc(5'd2);
    chk("pre_rst_dis", dis_ptr, 2'd2);
    rst = 1'b1; disp_oitf_ena = 1'b1; disp_oitf_rdwen = 1'b1; disp_oitf_rdidx = 5'd3;
    tick();
    rst = 1'b0; disp_oitf_ena = 1'b0; disp_oitf_rdwen = 1'b0;
    disp_oitf_rs1idx = 5'd1;
    #1;
    chk("rst2_empty", oitf_empty, 1'b1);
    chk("rst2_dis_ptr", dis_ptr, 2'd0);
    chk("rst2_ret_ptr", ret_ptr, 2'd0);
    chk("rst2_match", oitfrd_match_disprs1, 1'b0);
    chk("rst2_ret_rdidx", ret_rdidx, 5'd0);

    // ten allocate/retire pairs against a scoreboard queue
    alloc(5'd20);
    exp_q.push_back(5'd20);
    exp_rp = 2'd0;
    for (int i = 0; i < 10; i++) begin
      disp_oitf_ena = 1'b1; disp_oitf_rdwen = 1'b1;
      disp_oitf_rdidx = 5'(21 + i);
      ret_ena = 1'b1;
      #1;
      chk("pair_rdidx", ret_rdidx, exp_q[0]);
      chk("pair_ret_ptr", ret_ptr, exp_rp);
      exp_q.push_back(5'(21 + i));
      void'(exp_q.pop_front());
      exp_rp = exp_rp + 2'd1;
      tick();
    end
    disp_oitf_ena = 1'b0; disp_oitf_rdwen = 1'b0;
    #1;
    chk("drain_rdidx", ret_rdidx, exp_q[0]);
    chk("drain_empty", oitf_empty, 1'b0);
    tick();
    ret_ena = 1'b0;
    chk("drain_done", oitf_empty, 1'b1);
    chk("drain_ret_ptr", ret_ptr, exp_rp + 2'd1);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
